ad9122_spi_arbiter: RTL

AD9122_SPI_ARBITER -- requirements
Module: ad9122_spi_arbiter

---
 rtl/ad9122_spi_arbiter.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/ad9122_spi_arbiter.sv
// Three-port round-robin arbiter in front of an AD9122 SPI word engine.
// One command in flight; each grant gets exactly one response (data or timeout).
module ad9122_spi_arbiter #(
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic [2:0]  req_valid,
  output logic [2:0]  req_ready,
  input  logic [2:0]  req_rw,
  input  logic [20:0] req_addr,
  input  logic [23:0] req_wdata,
  output logic [2:0]  rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic        spi_cmd_valid,
  input  logic        spi_cmd_ready,
  output logic [15:0] spi_cmd_word,
  input  logic        spi_done,
  input  logic [7:0]  spi_rdata,
  output logic        busy,
  output logic [1:0]  grant_id
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_DONE,
    RESPOND,
    GAP
  } state_t;

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES);
  localparam logic [GW-1:0] GAP_LAST =
    GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t        state_q, state_d;
  logic [1:0]    last_grant_q, last_grant_d;
  logic [1:0]    grant_q, grant_d;
  logic          cmd_valid_q, cmd_valid_d;
  logic [15:0]   cmd_word_q, cmd_word_d;
  logic          is_rd_q, is_rd_d;
  logic [2:0]    rsp_valid_q, rsp_valid_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          err_q, err_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [GW-1:0] gcnt_q, gcnt_d;
  logic          busy_q, busy_d;

  logic [1:0]    sel;
  logic          sel_hit;
  logic          sel_rw;
  logic [6:0]    sel_addr;
  logic [7:0]    sel_wdata;

  function automatic logic [1:0] rr_port(
    input logic [1:0] last,
    input int         k
  );
    int p;
    p = (int'(last) + 1 + k) % 3;
    return 2'(p);
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] p);
    return 3'b001 << p;
  endfunction

  // Scan from the farthest candidate down so the nearest one wins.
  always_comb begin
    sel     = 2'd0;
    sel_hit = 1'b0;
    for (int k = 2; k >= 0; k--) begin
      if (req_valid[rr_port(last_grant_q, k)]) begin
        sel     = rr_port(last_grant_q, k);
        sel_hit = 1'b1;
      end
    end
  end

  always_comb begin
    unique case (sel)
      2'd1: begin
        sel_rw    = req_rw[1];
        sel_addr  = req_addr[13:7];
        sel_wdata = req_wdata[15:8];
      end
      2'd2: begin
        sel_rw    = req_rw[2];
        sel_addr  = req_addr[20:14];
        sel_wdata = req_wdata[23:16];
      end
      default: begin
        sel_rw    = req_rw[0];
        sel_addr  = req_addr[6:0];
        sel_wdata = req_wdata[7:0];
      end
    endcase
  end

  // Accept is combinational so a request withdrawn before the edge is never taken.
  assign req_ready = (state_q == IDLE && sel_hit && !rst)
                     ? onehot(sel) : 3'b000;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    cmd_valid_d  = cmd_valid_q;
    cmd_word_d   = cmd_word_q;
    is_rd_d      = is_rd_q;
    rsp_valid_d  = 3'b000;
    rdata_d      = rdata_q;
    err_d        = err_q;
    tcnt_d       = tcnt_q;
    gcnt_d       = gcnt_q;
    unique case (state_q)
      IDLE: begin
        if (sel_hit) begin
          grant_d      = sel;
          last_grant_d = sel;
          is_rd_d      = sel_rw;
          cmd_word_d   = sel_rw ? {1'b1, sel_addr, 8'h00}
                                : {1'b0, sel_addr, sel_wdata};
          cmd_valid_d  = 1'b1;
          tcnt_d       = '0;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        if (tcnt_q == TO_MAX) begin
          cmd_valid_d = 1'b0;
          rdata_d     = 8'h00;
          err_d       = 1'b1;
          rsp_valid_d = onehot(grant_q);
          state_d     = RESPOND;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
          if (spi_cmd_ready) begin
            cmd_valid_d = 1'b0;
            state_d     = WAIT_DONE;
          end
        end
      end
      WAIT_DONE: begin
        if (spi_done) begin
          rdata_d     = is_rd_q ? spi_rdata : 8'h00;
          err_d       = 1'b0;
          rsp_valid_d = onehot(grant_q);
          state_d     = RESPOND;
        end else if (tcnt_q == TO_MAX) begin
          rdata_d     = 8'h00;
          err_d       = 1'b1;
          rsp_valid_d = onehot(grant_q);
          state_d     = RESPOND;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      RESPOND: begin
        gcnt_d = '0;
        if (GAP_CYCLES == 0) state_d = IDLE;
        else                 state_d = GAP;
      end
      GAP: begin
        if (gcnt_q == GAP_LAST) state_d = IDLE;
        else                    gcnt_d  = gcnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 2'd2;
      grant_q      <= 2'd0;
      cmd_valid_q  <= 1'b0;
      cmd_word_q   <= 16'h0000;
      is_rd_q      <= 1'b0;
      rsp_valid_q  <= 3'b000;
      rdata_q      <= 8'h00;
      err_q        <= 1'b0;
      tcnt_q       <= '0;
      gcnt_q       <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_word_q   <= cmd_word_d;
      is_rd_q      <= is_rd_d;
      rsp_valid_q  <= rsp_valid_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      tcnt_q       <= tcnt_d;
      gcnt_q       <= gcnt_d;
      busy_q       <= busy_d;
    end
  end

  assign spi_cmd_valid = cmd_valid_q;
  assign spi_cmd_word  = cmd_word_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rdata_q;
  assign rsp_err       = err_q;
  assign busy          = busy_q;
  assign grant_id      = grant_q;

endmodule
